// File: rtl/maxpool2x2_stream.sv
// maxpool2x2_stream: streaming 2x2, stride-2 max-pooling stage.
//
// Pixels arrive row-major, one per accepted handshake. Even rows are reduced
// horizontally into a half-width line buffer; each odd-row pixel pair completes
// a window against that buffer and loads a one-entry output register.
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-high reset
//   in_valid   in_data holds a pixel
//   in_ready   stage can accept a pixel this cycle
//   in_data    input pixel, two's-complement signed
//   out_valid  out_data holds a pooled pixel
//   out_ready  downstream accepts out_data this cycle
//   out_data   pooled pixel, two's-complement signed
//   out_last   out_data is the final pooled pixel of the frame
module maxpool2x2_stream #(
   parameter int unsigned data_width = 16,
   parameter int unsigned map_width  = 8,
   parameter int unsigned map_height = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [data_width-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [data_width-1:0] out_data,
   output logic                  out_last
);

   localparam int unsigned ColW    = $clog2(map_width);
   localparam int unsigned RowW    = $clog2(map_height);
   localparam int unsigned LbDepth = map_width / 2;
   localparam int unsigned LbW     = (LbDepth > 1) ? $clog2(LbDepth) : 1;

   localparam logic [ColW-1:0] ColLast = ColW'(map_width - 1);
   localparam logic [RowW-1:0] RowLast = RowW'(map_height - 1);

   // Position counters and pair register
   logic [ColW-1:0]              col_q, col_d;
   logic [RowW-1:0]              row_q, row_d;
   logic signed [data_width-1:0] hold_q, hold_d;

   // One-entry output buffer
   logic                         out_valid_q, out_valid_d;
   logic signed [data_width-1:0] out_data_q, out_data_d;
   logic                         out_last_q, out_last_d;

   // Half-width line buffer; every entry is written in an even row before the
   // following odd row reads it, so it needs no reset.
   logic signed [data_width-1:0] linebuf_q [LbDepth];

   logic                         accept;
   logic                         lb_we;
   logic                         new_res;
   logic                         frame_end;
   logic [LbW-1:0]               lb_idx;
   logic signed [data_width-1:0] pix;
   logic signed [data_width-1:0] pair_max;
   logic signed [data_width-1:0] lb_rd;
   logic signed [data_width-1:0] win_max;

   // Ready whenever the output slot is empty or is being drained this cycle.
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   assign lb_idx = LbW'(col_q >> 1);
   assign pix    = $signed(in_data);

   // All comparisons are between signed operands.
   assign pair_max = (hold_q > pix) ? hold_q : pix;
   assign lb_rd    = linebuf_q[lb_idx];
   assign win_max  = (lb_rd > pair_max) ? lb_rd : pair_max;

   assign lb_we     = accept && col_q[0] && !row_q[0];
   assign new_res   = accept && col_q[0] && row_q[0];
   assign frame_end = (row_q == RowLast) && (col_q == ColLast);

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;

      if (accept) begin
         if (col_q == ColLast) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + RowW'(1);
         end else begin
            col_d = col_q + ColW'(1);
         end
         if (!col_q[0]) begin
            hold_d = pix;
         end
      end

      // A new result takes priority: it either fills an empty slot or replaces
      // the entry that is being emitted in this same cycle.
      if (new_res) begin
         out_valid_d = 1'b1;
         out_data_d  = win_max;
         out_last_d  = frame_end;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_q       <= '0;
         row_q       <= '0;
         hold_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         hold_q      <= hold_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
      end
   end

   always_ff @(posedge clk) begin
      if (lb_we) begin
         linebuf_q[lb_idx] <= pair_max;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

endmodule
